// File: rtl/booth_mul_seq.sv
// Sequential signed radix-4 Booth multiplier: one partial product per cycle
// through a single shared 2*WIDTH-bit adder, valid/ready on both sides.
module booth_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   m,
    input  logic [WIDTH-1:0]   x,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int NDIG = WIDTH / 2;
    localparam int PW   = 2 * WIDTH;
    localparam int CW   = $clog2(NDIG);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   prod_q, prod_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [2:0]      trip;
    logic            dig_zero, dig_two, dig_neg;
    logic [PW-1:0]   m_ext, mag, shifted, addend, acc_sum;

    // Booth triplet {x[2i+1], x[2i], x[2i-1]} with x[-1] = 0.
    assign trip = 3'({x_q, 1'b0} >> {cnt_q, 1'b0});

    always_comb begin
        dig_zero = 1'b0;
        dig_two  = 1'b0;
        dig_neg  = 1'b0;
        case (trip)
            3'b000, 3'b111: dig_zero = 1'b1;
            3'b001, 3'b010: ;
            3'b011:         dig_two  = 1'b1;
            3'b100: begin
                dig_two = 1'b1;
                dig_neg = 1'b1;
            end
            default:        dig_neg  = 1'b1;
        endcase
    end

    // Negation folded into the shared adder as invert plus carry-in.
    assign m_ext   = {{WIDTH{m_q[WIDTH-1]}}, m_q};
    assign mag     = dig_zero ? '0 : (dig_two ? (m_ext << 1) : m_ext);
    assign shifted = mag << {cnt_q, 1'b0};
    assign addend  = dig_neg ? ~shifted : shifted;
    assign acc_sum = acc_q + addend + PW'(dig_neg);

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        x_d       = x_q;
        acc_d     = acc_q;
        prod_d    = prod_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            ACCUM: begin
                busy  = 1'b1;
                acc_d = acc_sum;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(NDIG - 1)) begin
                    prod_d  = acc_sum;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (in_valid && in_ready) begin
            m_d     = m;
            x_d     = x;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ACCUM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            x_q     <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            x_q     <= x_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
        end
    end

    assign product = prod_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: directed corner cases plus random
// traffic scored against a signed-multiply queue model.
module tb_booth_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  m = '0;
    logic [7:0]  x = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] product;
    logic        busy;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned n_acc = 0;
    int unsigned n_res = 0;
    logic [15:0] exp_q[$];
    logic        rand_bp = 1'b0;

    booth_mul_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .m         (m),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p[15:0];
    endfunction

    // Scoreboard: handshakes are sampled mid-cycle, when inputs are settled.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                n_res++;
                if (exp_q.size() == 0) check("spurious_result", 32'd1, 32'd0);
                else check("product", 32'(product), 32'(exp_q.pop_front()));
            end
            if (in_valid && in_ready) begin
                n_acc++;
                exp_q.push_back(ref_mul(m, x));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        m = a;
        x = b;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        m = 8'($urandom);
        x = 8'($urandom);
    endtask

    task automatic wait_valid(output int edges, output int busy_cycles);
        edges = 0;
        busy_cycles = 0;
        while (!out_valid && edges < 100) begin
            if (busy) busy_cycles++;
            @(posedge clk);
            #1;
            edges++;
        end
        if (!out_valid) check("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b);
        int e, bc;
        out_ready = 1'b1;
        send(a, b);
        wait_valid(e, bc);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int e, bc;
        logic [7:0] ra, rb;

        #12;
        check("rst_product", 32'(product), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Latency and busy duration
        out_ready = 1'b1;
        send(8'd10, 8'd10);
        wait_valid(e, bc);
        check("latency_10x10", 32'(e + 1), 32'd5);
        check("busy_cycles", 32'(bc), 32'd4);
        check("prod_10x10", 32'(product), 32'd100);
        @(posedge clk);
        #1;
        check("out_valid_drop", 32'(out_valid), 32'd0);

        run_op(8'h80, 8'h80);
        run_op(8'h7F, 8'h80);
        run_op(8'hFF, 8'hFF);
        run_op(8'h00, 8'hB3);

        // Back-to-back sweep
        out_ready = 1'b1;
        send(8'd15, 8'd20);
        for (int k = 2; k <= 12; k++) send(8'(10 * k), 8'(10 * k + 10));
        drain();

        // Random traffic with random backpressure
        rand_bp = 1'b1;
        fork
            begin
                while (rand_bp) begin
                    @(posedge clk);
                    #1;
                    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            ra = 8'($urandom);
            rb = 8'($urandom);
            send(ra, rb);
        end
        rand_bp = 1'b0;
        @(posedge clk);
        #1;
        drain();

        // Backpressure hold
        out_ready = 1'b0;
        send(8'd11, 8'hFD);
        wait_valid(e, bc);
        for (int c = 0; c < 7; c++) begin
            @(posedge clk);
            #1;
            check("bp_product", 32'(product), 32'h0000FFDF);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b1;
        m = 8'd3;
        x = 8'hFB;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(e, bc);
        check("bp_next_latency", 32'(e + 1), 32'd5);
        check("bp_next_product", 32'(product), 32'h0000FFF1);
        @(posedge clk);
        #1;

        // Reset in the second ACCUM cycle
        send(8'd100, 8'd50);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_product", 32'(product), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        n_acc = n_acc - exp_q.size();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        send(8'd6, 8'd7);
        wait_valid(e, bc);
        check("midrst_latency", 32'(e + 1), 32'd5);
        check("midrst_product42", 32'(product), 32'd42);
        @(posedge clk);
        #1;

        // Operands changed during ACCUM must be ignored
        send(8'd9, 8'd9);
        m = 8'hFF;
        x = 8'hFF;
        wait_valid(e, bc);
        check("opchg_product", 32'(product), 32'd81);
        @(posedge clk);
        #1;

        drain();
        check("acc_vs_res", n_res, n_acc);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/booth_mul_seq.md
Name: booth_mul_seq

Overview:
Multi-cycle signed radix-4 Booth multiplier controller. It accepts one operand pair through a valid/ready handshake and generates one Booth partial product per cycle. Each partial product is accumulated through a single shared 2*WIDTH-bit adder, replacing the three-adder combinational tree. The result is presented on a valid/ready output handshake. It sits between an operand source and a result consumer wherever area matters more than latency.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 4; product is 2*WIDTH bits; NDIG = WIDTH/2 Booth digits.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair m/x valid
in_ready  output  1  block can accept operands this cycle
m  input  WIDTH  signed multiplicand
x  input  WIDTH  signed multiplier
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
product  output  2*WIDTH  signed product m*x
busy  output  1  high in ACCUM

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE.
  - product=0, out_valid=0, busy=0.
  - internal accumulator, digit counter and operand registers = 0.
  - in_ready=1 once rst_n deasserts.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: register m and x, clear the accumulator, set counter=0, go to ACCUM.
- ACCUM (NDIG cycles, counter 0..NDIG-1). Each cycle:
  - Digit i uses bits {x[2i+1], x[2i], x[2i-1]}, with x[-1]=0.
  - Digit encoding:
    - 000 or 111 -> 0
    - 001 or 010 -> +M
    - 011 -> +2M
    - 100 -> -2M
    - 101 or 110 -> -M
  - Partial product = digit*M, sign-extended to 2*WIDTH, shifted left by 2i. Accumulator += partial product, modulo 2^(2*WIDTH).
  - After counter=NDIG-1, go to DONE.
  - in_ready=0 throughout; the zero digit still consumes its cycle.
- DONE:
  - out_valid=1; product = accumulator, held stable while out_valid && !out_ready.
  - On out_ready: the product is consumed.
    - If in_valid is also high in the same cycle, capture the new operands and go directly to ACCUM.
    - Otherwise go to IDLE.
  - in_ready = out_ready in DONE.
- Latency: the accept edge counts as cycle 0. out_valid rises after the NDIG-th ACCUM edge, i.e. NDIG+1 rising edges after accept (5 for WIDTH=8).
- Throughput with a consumer that is always ready: one result every NDIG+1 cycles.
- out_valid deasserts in the cycle after the consuming handshake unless a new result is immediately ready (never true for NDIG>=1).
- product keeps its last value after consumption until the next DONE. Consumers must only sample it when out_valid=1.
- Arithmetic is exact for all inputs. The full-range case (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2) fits in 2*WIDTH signed bits.
- Operand inputs are ignored outside the accept cycle; changing m/x during ACCUM has no effect.
- Reset mid-operation (any state): immediate return to reset values. No partial result is ever flagged valid.
- in_valid held while the block is busy: the request stays pending and is accepted at the next in_ready=1 cycle. No operand pair is dropped or duplicated.

Test Plan:
- After reset: m=10, x=10, in_valid pulse, out_ready=1 -> out_valid rises exactly 5 edges after accept; product=100; busy high for 4 cycles.
- Sign corners:
  - m=-128, x=-128 -> product=16384.
  - m=127, x=-128 -> product=-16256.
  - m=8'hFF, x=8'hFF -> product=1.
  - m=0, x=-77 -> product=0.
- Sweep pairs (15,20), (20,30), ..., (120,130) as signed 8-bit, plus 1000 random pairs -> product matches the signed reference m*x every time, with no skipped or duplicated results.
- Backpressure: out_ready=0 for 7 cycles after out_valid -> product and out_valid stable, in_ready=0. Raise out_ready together with in_valid (m=3, x=-5) -> first result consumed; next result -15 arrives 5 edges later.
- Reset mid-op: assert rst_n=0 during the 2nd ACCUM cycle -> outputs go to 0 asynchronously. After release, a new m=6, x=7 yields 42 with correct latency.
- Operand change during ACCUM: present m=9, x=9, accept, then drive m=x=-1 -> product=81.
